// File: rtl/prism_cfg_pkg.sv
// Shared types, register map and helpers for the PRISM configuration loader.
// No logic; no latency or backpressure of its own.
package prism_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_GAP   = 3'd3,
        ST_STEP  = 3'd4
    } state_t;

    localparam logic [5:0] ADDR_SHIFT  = 6'h10;
    localparam logic [5:0] ADDR_UPPER1 = 6'h14;
    localparam logic [5:0] ADDR_UPPER2 = 6'h18;
    localparam logic [5:0] ADDR_UPPER3 = 6'h1C;
    localparam logic [5:0] ADDR_DIRECT = 6'h20;
    localparam logic [5:0] ADDR_TGT    = 6'h24;

    function automatic int idx_bits(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/prism_cfg_cells.sv
// Behavioural model of the IHP 2-input AND standard cell for non-synthesis flows.
// Combinational; no backpressure.
`ifndef SYNTHESIS
module sg13g2_and2_1 (
    input  logic A,
    input  logic B,
    output logic X
);
    assign X = A & B;
endmodule
`endif

// File: rtl/prism_cfg_stage.sv
// Write decode and staging registers; trigger strobes are registered (1 cycle after the write).
// Writes are rejected (overrun set) while the loader is busy or a trigger is still pending.
module prism_cfg_stage
    import prism_cfg_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             debug_wr,
    input  logic [31:0]      data_in,
    input  logic [5:0]       address,
    input  logic             busy,
    output logic [WIDTH-1:0] config_data,
    output logic [4:0]       tgt_idx,
    output logic             shift_trig,
    output logic             direct_trig,
    output logic             overrun
);

    localparam int NW = WIDTH / 32;

    logic [NW-1:0] word_sel;
    logic          is_trig;
    logic          in_map;
    logic          block;
    logic          accept;
    logic          reject;

    always_comb begin
        word_sel    = '0;
        word_sel[0] = (address == ADDR_SHIFT) || (address == ADDR_DIRECT);
        for (int k = 1; k < NW; k++) begin
            word_sel[k] = (address == 6'(ADDR_SHIFT + 6'(4 * k)));
        end
    end

    assign is_trig = (address == ADDR_SHIFT) || (address == ADDR_DIRECT);
    assign in_map  = (|word_sel) || (address == ADDR_TGT);
    // A trigger still in flight to the FSM counts as busy so it cannot be overwritten.
    assign block   = busy | shift_trig | direct_trig;
    assign accept  = debug_wr & ~block;
    assign reject  = debug_wr & block & in_map;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            config_data <= '0;
            tgt_idx     <= '0;
            shift_trig  <= 1'b0;
            direct_trig <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            shift_trig  <= accept && (address == ADDR_SHIFT);
            direct_trig <= accept && (address == ADDR_DIRECT);
            if (accept) begin
                for (int k = 0; k < NW; k++) begin
                    if (word_sel[k]) config_data[32*k +: 32] <= data_in;
                end
                if (address == ADDR_TGT) tgt_idx <= data_in[4:0];
            end
            if (reject)                  overrun <= 1'b1;
            else if (accept && is_trig)  overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/prism_cfg_loader.sv
// Latch-chain loader: SHIFT walks DEPTH-1..0, DIRECT pulses one entry; first pulse 2 cycles after the write.
// Writes while busy are dropped and flagged through the sticky overrun bit.
module prism_cfg_loader
    import prism_cfg_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 64,
    parameter int PULSE_CYC = 1,
    parameter int GAP_CYC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             debug_wr,
    input  logic [31:0]      data_in,
    input  logic [5:0]       address,
    output logic [WIDTH-1:0] config_data,
    output logic [DEPTH-1:0] latch_en,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam int IW = idx_bits(DEPTH);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d, tgt_clamp;
    logic          mode_q, mode_d;
    logic          pulse_q;
    logic          done_q, done_d;
    logic [4:0]    tgt_idx;
    logic          shift_trig;
    logic          direct_trig;

    prism_cfg_stage #(.WIDTH(WIDTH)) u_stage (
        .clk         (clk),
        .rst_n       (rst_n),
        .debug_wr    (debug_wr),
        .data_in     (data_in),
        .address     (address),
        .busy        (busy),
        .config_data (config_data),
        .tgt_idx     (tgt_idx),
        .shift_trig  (shift_trig),
        .direct_trig (direct_trig),
        .overrun     (overrun)
    );

    assign tgt_clamp = (int'(tgt_idx) >= DEPTH) ? IW'(DEPTH - 1) : tgt_idx[IW-1:0];
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (shift_trig) begin
                    idx_d   = IW'(DEPTH - 1);
                    mode_d  = 1'b0;
                    state_d = ST_SETUP;
                end else if (direct_trig) begin
                    idx_d   = tgt_clamp;
                    mode_d  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_PULSE;
                cnt_d   = '0;
            end
            ST_PULSE: begin
                if (cnt_q == 4'(PULSE_CYC - 1)) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 4'(GAP_CYC - 1)) begin
                    cnt_d = '0;
                    if (mode_q || (idx_q == '0)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // Index moves only on the GAP->STEP edge, with enables low on both sides.
                        state_d = ST_STEP;
                        idx_d   = idx_q - IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_STEP: begin
                state_d = ST_PULSE;
                cnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            pulse_q <= (state_d == ST_PULSE);
            done_q  <= done_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_en
        logic sel;
        assign sel = (idx_q == IW'(i));
`ifdef SIM
        assign latch_en[i] = sel & pulse_q;
`else
        (* keep *) sg13g2_and2_1 u_and (.A(sel), .B(pulse_q), .X(latch_en[i]));
`endif
    end

endmodule

// File: tb/tb_prism_cfg_loader.sv
// Directed bench for prism_cfg_loader: four parameter sets driven from one vector table plus corner sequences.
module tb_prism_cfg_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   wr_sel;
    logic [31:0]  data_in;
    logic [5:0]   address;

    logic [63:0]  cfg0, cfg1;
    logic [127:0] cfg2;
    logic [31:0]  cfg3;
    logic [7:0]   en0, en2, en3;
    logic [3:0]   en1;
    logic [3:0]   busy_v, done_v, ovr_v;

    int n_chk = 0;
    int n_err = 0;
    int sel   = 0;

    always #5 clk = ~clk;

    prism_cfg_loader #(.DEPTH(8), .WIDTH(64), .PULSE_CYC(1), .GAP_CYC(1)) u_d0 (
        .clk(clk), .rst_n(rst_n), .debug_wr(wr_sel[0]), .data_in(data_in), .address(address),
        .config_data(cfg0), .latch_en(en0), .busy(busy_v[0]), .done(done_v[0]), .overrun(ovr_v[0]));
    prism_cfg_loader #(.DEPTH(4), .WIDTH(64), .PULSE_CYC(3), .GAP_CYC(2)) u_d1 (
        .clk(clk), .rst_n(rst_n), .debug_wr(wr_sel[1]), .data_in(data_in), .address(address),
        .config_data(cfg1), .latch_en(en1), .busy(busy_v[1]), .done(done_v[1]), .overrun(ovr_v[1]));
    prism_cfg_loader #(.DEPTH(8), .WIDTH(128), .PULSE_CYC(1), .GAP_CYC(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .debug_wr(wr_sel[2]), .data_in(data_in), .address(address),
        .config_data(cfg2), .latch_en(en2), .busy(busy_v[2]), .done(done_v[2]), .overrun(ovr_v[2]));
    prism_cfg_loader #(.DEPTH(8), .WIDTH(32), .PULSE_CYC(1), .GAP_CYC(1)) u_d3 (
        .clk(clk), .rst_n(rst_n), .debug_wr(wr_sel[3]), .data_in(data_in), .address(address),
        .config_data(cfg3), .latch_en(en3), .busy(busy_v[3]), .done(done_v[3]), .overrun(ovr_v[3]));

    logic [31:0]  mon_en;
    logic [127:0] mon_cfg;
    logic         mon_busy, mon_done, mon_ovr;

    always_comb begin
        mon_en   = 32'(en0);
        mon_cfg  = 128'(cfg0);
        mon_busy = busy_v[0];
        mon_done = done_v[0];
        mon_ovr  = ovr_v[0];
        case (sel)
            1: begin mon_en = 32'(en1); mon_cfg = 128'(cfg1); mon_busy = busy_v[1]; mon_done = done_v[1]; mon_ovr = ovr_v[1]; end
            2: begin mon_en = 32'(en2); mon_cfg = cfg2;       mon_busy = busy_v[2]; mon_done = done_v[2]; mon_ovr = ovr_v[2]; end
            3: begin mon_en = 32'(en3); mon_cfg = 128'(cfg3); mon_busy = busy_v[3]; mon_done = done_v[3]; mon_ovr = ovr_v[3]; end
            default: ;
        endcase
    end

    typedef struct packed {
        logic [1:0]        dut;
        logic [1:0]        npre;
        logic [2:0][5:0]   pre_a;
        logic [2:0][31:0]  pre_d;
        logic [5:0]        trig_a;
        logic [31:0]       trig_d;
        logic [127:0]      cfg;
        logic [4:0]        idx;
        logic [5:0]        npulse;
        logic [3:0]        pw;
        logic [4:0]        sp;
        logic [5:0]        nbusy;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input int dut, input int npre,
                                input logic [5:0] a0, input logic [31:0] d0,
                                input logic [5:0] a1, input logic [31:0] d1,
                                input logic [5:0] a2, input logic [31:0] d2,
                                input logic [5:0] ta, input logic [31:0] td,
                                input logic [127:0] cfg, input int idx, input int np,
                                input int pw, input int sp, input int nb);
        vec_t v;
        v.dut = 2'(dut);   v.npre = 2'(npre);
        v.pre_a[0] = a0;   v.pre_d[0] = d0;
        v.pre_a[1] = a1;   v.pre_d[1] = d1;
        v.pre_a[2] = a2;   v.pre_d[2] = d2;
        v.trig_a = ta;     v.trig_d = td;
        v.cfg = cfg;       v.idx = 5'(idx);
        v.npulse = 6'(np); v.pw = 4'(pw);
        v.sp = 5'(sp);     v.nbusy = 6'(nb);
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the sampling edge.
    task automatic wr(input int d, input logic [5:0] a, input logic [31:0] v);
        address = a;
        data_in = v;
        wr_sel  = 4'(1 << d);
        @(posedge clk);
        @(negedge clk);
        wr_sel  = '0;
    endtask

    task automatic observe(input string tag, input int exp_idx, input int exp_n, input int exp_p,
                           input int exp_s, input int exp_busy, input bit chk_tail);
        int c_done = -1, first = -1, n = 0, width = 0, prev_start = 0, busy_n = 0;
        int bad_w = 0, bad_s = 0, bad_v = 0, bad_oh = 0;
        logic busy_at_done = 1'b1;
        logic [31:0] en, prev_en = '0, exp_v;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            en = mon_en;
            if (!$onehot0(en)) bad_oh++;
            if (en != 0 && prev_en != 0 && en != prev_en) bad_oh++;
            if (en != 0) begin
                if (prev_en == 0) begin
                    if (n == 0) first = c;
                    else if (c - prev_start != exp_s) bad_s++;
                    exp_v = (n <= exp_idx) ? (32'h1 << (exp_idx - n)) : 32'h0;
                    if (en != exp_v) bad_v++;
                    prev_start = c;
                    n++;
                    width = 1;
                end else begin
                    width++;
                end
            end else if (prev_en != 0 && width != exp_p) begin
                bad_w++;
            end
            if (mon_busy) busy_n++;
            prev_en = en;
            if (mon_done) begin
                c_done = c;
                busy_at_done = mon_busy;
                break;
            end
        end
        check({tag, "_done_seen"},  128'(c_done > 0), 128'(1));
        check({tag, "_first_edge"}, 128'(first), 128'(2));
        check({tag, "_npulses"},    128'(n), 128'(exp_n));
        check({tag, "_busy_cyc"},   128'(busy_n), 128'(exp_busy));
        check({tag, "_busy_done"},  128'(busy_at_done), 128'(0));
        check({tag, "_bad_width"},  128'(bad_w), 128'(0));
        check({tag, "_bad_space"},  128'(bad_s), 128'(0));
        check({tag, "_bad_entry"},  128'(bad_v), 128'(0));
        check({tag, "_overlap"},    128'(bad_oh), 128'(0));
        if (chk_tail) begin
            @(negedge clk);
            check({tag, "_done_1cyc"}, 128'(mon_done), 128'(0));
            check({tag, "_en_idle"},   128'(mon_en), 128'(0));
        end
    endtask

    task automatic run_rec(input vec_t v, input int k);
        sel = int'(v.dut);
        for (int i = 0; i < int'(v.npre); i++) wr(sel, v.pre_a[i], v.pre_d[i]);
        wr(sel, v.trig_a, v.trig_d);
        check($sformatf("v%0d_cfg", k), mon_cfg, v.cfg);
        observe($sformatf("v%0d", k), int'(v.idx), int'(v.npulse), int'(v.pw),
                int'(v.sp), int'(v.nbusy), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dcount;
        vecs[0] = mk(0, 1, 6'h14, 32'hDEADBEEF, 6'h0, 0, 6'h0, 0, 6'h10, 32'h12345678,
                     128'hDEADBEEF_12345678, 7, 8, 1, 3, 24);
        vecs[1] = mk(0, 1, 6'h24, 32'd5, 6'h0, 0, 6'h0, 0, 6'h20, 32'hA5A5A5A5,
                     128'hDEADBEEF_A5A5A5A5, 5, 1, 1, 3, 3);
        vecs[2] = mk(0, 1, 6'h24, 32'd31, 6'h0, 0, 6'h0, 0, 6'h20, 32'h0,
                     128'hDEADBEEF_00000000, 7, 1, 1, 3, 3);
        vecs[3] = mk(0, 1, 6'h24, 32'd0, 6'h0, 0, 6'h0, 0, 6'h20, 32'h1,
                     128'hDEADBEEF_00000001, 0, 1, 1, 3, 3);
        vecs[4] = mk(1, 1, 6'h14, 32'h11111111, 6'h0, 0, 6'h0, 0, 6'h10, 32'h22222222,
                     128'h11111111_22222222, 3, 4, 3, 6, 24);
        vecs[5] = mk(2, 3, 6'h14, 32'hAAAA0001, 6'h18, 32'hBBBB0002, 6'h1C, 32'hCCCC0003,
                     6'h10, 32'hDDDD0000,
                     128'hCCCC0003_BBBB0002_AAAA0001_DDDD0000, 7, 8, 1, 3, 24);
        vecs[6] = mk(3, 1, 6'h14, 32'hFFFFFFFF, 6'h0, 0, 6'h0, 0, 6'h10, 32'h0BADF00D,
                     128'h0BADF00D, 7, 8, 1, 3, 24);

        rst_n = 1'b0; wr_sel = '0; address = '0; data_in = '0; sel = 0;
        repeat (3) @(negedge clk);
        check("rst_cfg",  mon_cfg,  128'h0);
        check("rst_en",   mon_en,   128'h0);
        check("rst_busy", mon_busy, 128'h0);
        check("rst_done", mon_done, 128'h0);
        check("rst_ovr",  mon_ovr,  128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", mon_busy, 128'h0);

        for (int k = 0; k < 7; k++) run_rec(vecs[k], k);

        // Writes during a sequence are dropped and flagged.
        sel = 0;
        wr(0, 6'h10, 32'h55);
        repeat (3) @(negedge clk);
        wr(0, 6'h14, 32'h1);
        wr(0, 6'h10, 32'h99);
        check("ovr_cfg_kept", mon_cfg, 128'hDEADBEEF_00000055);
        check("ovr_set",      mon_ovr, 128'h1);
        for (int i = 0; i < 100 && mon_busy; i++) @(negedge clk);
        check("ovr_wait_idle", mon_busy, 128'h0);
        check("ovr_done_cyc",  mon_done, 128'h1);
        check("ovr_sticky",    mon_ovr,  128'h1);

        // Trigger in the done cycle is accepted and clears overrun.
        wr(0, 6'h10, 32'h1);
        check("ovr_clear", mon_ovr, 128'h0);
        check("co_cfg",    mon_cfg, 128'hDEADBEEF_00000001);
        observe("co_shift", 7, 8, 1, 3, 24, 1'b0);
        wr(0, 6'h20, 32'h2);
        check("co_ovr", mon_ovr, 128'h0);
        check("co_direct_cfg", mon_cfg, 128'hDEADBEEF_00000002);
        observe("co_direct", 0, 1, 1, 3, 3, 1'b1);

        // Reset while entry 3 is being pulsed.
        wr(0, 6'h10, 32'h3C);
        for (int i = 0; i < 100 && mon_en != 32'h8; i++) @(negedge clk);
        check("mid_en3_seen", mon_en, 128'h8);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_en",   mon_en,   128'h0);
        check("mid_rst_busy", mon_busy, 128'h0);
        check("mid_rst_cfg",  mon_cfg,  128'h0);
        check("mid_rst_done", mon_done, 128'h0);
        dcount = 0;
        repeat (4) begin
            @(negedge clk);
            dcount += int'(mon_done);
        end
        check("mid_rst_no_done", 128'(dcount), 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        wr(0, 6'h10, 32'h77);
        check("fresh_cfg", mon_cfg, 128'h77);
        observe("fresh", 7, 8, 1, 3, 24, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/prism_cfg_loader.md
Name: prism_cfg_loader

Overview:
- Parametrised successor to the PRISM configuration latch-chain loader.
- Sequences clean, non-overlapping latch-enable pulses that either shift a configuration word through a DEPTH-entry latch array or write one selected entry directly.
- Adds multi-word staging (WIDTH up to 128), programmable pulse and gap timing, busy/done/overrun status, and a direct single-entry write mode.
- Sits between the TinyQV peripheral register interface and the PRISM state-table latch array.

Parameters:
- DEPTH, 8: number of latch entries; 2..32.
- WIDTH, 64: configuration word width; one of 32, 64, 96 or 128.
- PULSE_CYC, 1: cycles latch_en is held high per entry; 1..15.
- GAP_CYC, 1: low cycles after each pulse before the index changes; 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- debug_wr  in  1  one-cycle peripheral write strobe.
- data_in  in  32  write data from the RISC-V.
- address  in  6  byte address of the write.
- config_data  out  WIDTH  staged configuration word driven to the latch array.
- latch_en  out  DEPTH  per-entry latch enables, active high, at most one high at a time.
- busy  out  1  high while a sequence is in progress.
- done  out  1  one-cycle pulse when a sequence completes.
- overrun  out  1  sticky; a write was rejected while busy.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE; index 0; all staging registers 0; config_data 0; latch_en 0; busy 0; done 0; overrun 0.
- Register map, all actions taken when debug_wr is high:
  - 0x10: capture data_in into lsb_word; start a SHIFT sequence.
  - 0x14, 0x18, 0x1C: capture data_in into upper word k = 1, 2, 3. Only addresses with k < WIDTH/32 exist; the others are ignored.
  - 0x20: capture data_in into lsb_word; start a DIRECT sequence.
  - 0x24: capture data_in[4:0] into tgt_idx. Values >= DEPTH are stored but clamp to DEPTH-1 at use.
  - All other addresses are ignored.
- config_data = {upper words, lsb_word}, truncated to WIDTH. It changes only on an accepted write.
- Write accepted while busy=0. While busy=1 every write in the map is rejected: no state change, no data capture, overrun <= 1.
- overrun clears on the next accepted trigger write (0x10 or 0x20).
- States: IDLE, SETUP, PULSE, GAP, STEP. A 4-bit cycle counter is shared by PULSE and GAP.
  - IDLE: on a SHIFT trigger, index <= DEPTH-1. On a DIRECT trigger, index <= min(tgt_idx, DEPTH-1). Either trigger goes to SETUP.
  - SETUP: 1 cycle, data settling. Goes to PULSE with cnt=0.
  - PULSE: latch_en[index] high. After PULSE_CYC cycles goes to GAP with cnt=0.
  - GAP: latch_en all low. After GAP_CYC cycles:
    - to IDLE if mode is DIRECT or index == 0; done is high for the first IDLE cycle;
    - otherwise to STEP, with index <= index-1 on that edge.
  - STEP: 1 low cycle, then PULSE.
- The index changes only while latch_en is all low, with at least one low cycle on each side of every change.
- latch_en[i] = (index == i) AND pulse_q, where pulse_q is a registered bit that is high exactly in PULSE. Under `ifdef SIM` use a plain AND. Otherwise use kept sg13g2_and2_1 cells, one per bit.
- busy is high in every state except IDLE.
- Timing, with the trigger sampled at edge 0:
  - the first pulse is high from edge 2 to edge 2+PULSE_CYC;
  - each subsequent entry starts PULSE_CYC+GAP_CYC+1 cycles after the previous one;
  - SHIFT total busy cycles = 1 + DEPTH*(PULSE_CYC+GAP_CYC) + (DEPTH-1).
- DIRECT trigger with index 0 behaves identically to the last step of a SHIFT.
- A trigger coincident with the done cycle is accepted, because busy is already 0.
- Reset asserted mid-sequence: latch_en drops asynchronously and all state returns to reset values; no done pulse is produced.

Decomposition:
- Package prism_cfg_pkg:
  - state enum (3-bit);
  - address constants ADDR_SHIFT=0x10, ADDR_UPPER1..3, ADDR_DIRECT=0x20, ADDR_TGT=0x24;
  - function idx_bits(DEPTH).
- Sub-module prism_cfg_stage holds lsb_word, the upper staging words and tgt_idx. It performs the write decode with busy gating and produces config_data and the trigger strobes.
- The loader FSM, counters and AND cells stay in prism_cfg_loader.

Test Plan:
- Reset, then SHIFT with DEPTH=8, PULSE_CYC=1, GAP_CYC=1, 0x14<=0xDEADBEEF, 0x10<=0x12345678 -> config_data=0xDEADBEEF_12345678; latch_en one-hot pulses 0x80, 0x40 ... 0x01, 3 cycles apart; first pulse at edge 2; busy for 24 cycles; one done pulse.
- DIRECT: 0x24<=5, 0x20<=0xA5A5A5A5 -> a single pulse on latch_en[5] only (0x20), then done; 0x24<=31 -> the pulse lands on latch_en[7].
- PULSE_CYC=3, GAP_CYC=2, DEPTH=4 -> each pulse is 3 cycles wide; the index change is always bracketed by low cycles; busy=1+4*5+3=24 cycles.
- Write 0x14<=0x1 and 0x10 mid-sequence -> both ignored, config_data unchanged, overrun=1; the next accepted 0x10 clears overrun.
- rst_n low while latch_en[3] is high -> latch_en=0 immediately, busy=0, config_data=0, no done pulse; a fresh SHIFT afterwards completes normally.
- WIDTH=128: write 0x14/0x18/0x1C then 0x10 -> all four words appear in order on config_data; with WIDTH=32, writes to 0x14 leave config_data unchanged.
